// File: rtl/bitrev_pkg.sv
// bitrev_pkg: shared width default, counter sizing and bit-order mode encodings
package bitrev_pkg;
  localparam int WIDTH_DEF = 32;
  localparam logic MODE_MSB = 1'b1;
  localparam logic MODE_LSB = 1'b0;
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/rev_out_buffer.sv
// rev_out_buffer: one-deep valid/ready holding register for assembled words
module rev_out_buffer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  // A load always wins over a drain, so load+drain in one cycle keeps valid high
  always_comb begin
    valid_d = load | (valid_q & ~out_ready);
    data_d  = load ? load_data : data_q;
  end
  // Holding register; data only changes on a load, so it is stable while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign out_valid = valid_q;
  assign out_data  = data_q;
endmodule

// File: rtl/bitrev_deserializer.sv
// bitrev_deserializer: serial-to-parallel word assembler with per-word MSB/LSB-first ordering
module bitrev_deserializer
  import bitrev_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  localparam int CNT_W = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  input  logic             msb_first,
  input  logic             clear,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] bit_cnt
);
  logic [WIDTH-1:0] sh_q, sh_d, sh_next;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d, mode_cur, last, accept, load;
  // The first bit of a word uses msb_first directly; later bits use the latched mode
  always_comb begin
    last     = cnt_q == CNT_W'(WIDTH - 1);
    in_ready = ~(last & out_valid & ~out_ready);
    accept   = in_valid & in_ready & ~clear;
    mode_cur = (cnt_q == '0) ? msb_first : mode_q;
    sh_next  = (mode_cur == MODE_MSB) ? {sh_q[WIDTH-2:0], in_bit} : {in_bit, sh_q[WIDTH-1:1]};
    load     = accept & last;
    sh_d     = clear ? '0 : (accept ? sh_next : sh_q);
    cnt_d    = clear ? '0 : (accept ? (last ? '0 : cnt_q + 1'b1) : cnt_q);
    mode_d   = (accept & (cnt_q == '0)) ? msb_first : mode_q;
  end
  // Shift register, bit counter and per-word mode latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      mode_q <= MODE_MSB;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
    end
  end
  assign bit_cnt = cnt_q;
  rev_out_buffer #(.WIDTH(WIDTH)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (sh_next),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data)
  );
endmodule
